spi_arbiter: RTL and testbench

SPI_ARBITER -- requirements
Module: spi_arbiter

---
 rtl/zx_spi_pkg.sv | 21 ++
 rtl/spi_rr.sv | 11 +
 rtl/spi_arbiter.sv | 163 ++++++++++++++++
 tb/tb_spi_arbiter.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/zx_spi_pkg.sv
// Shared definitions for the SPI bus arbiter: sequencer state encoding,
// default transfer length and the counter sizing helper.
package zx_spi_pkg;

  // Default number of engine clock-enable ticks per byte transfer.
  localparam int SPI_CYCLES_DEFAULT = 16;

  // Sequencer states (plain constants so older tools can consume them).
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_BUSY  = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  typedef logic [1:0] spi_state_t;

  // Tick counter width: just wide enough to hold CYCLES-1 without wrapping.
  function automatic int spi_cnt_width(input int cycles);
    return (cycles > 1) ? $clog2(cycles) : 1;
  endfunction

endpackage

// File: rtl/spi_rr.sv
// Two-way round-robin grant: with both requesters contending, the one that
// was not served last wins; with a single contender, that contender wins.
module spi_rr (
  input  logic [1:0] i_req,     // bit 0 = requester A, bit 1 = requester B
  input  logic       i_last,    // requester served most recently (0=A, 1=B)
  output logic       o_winner   // 0=A, 1=B; meaningless when i_req is zero
);

  assign o_winner = (i_req == 2'b11) ? ~i_last : i_req[1];

endmodule

// File: rtl/spi_arbiter.sv
// Shares one external SPI byte engine between requester A (CPU port path)
// and requester B (loader). The owner keeps the bus, and the card chip
// select, until it idles with its cs high and its req low.
module spi_arbiter
  import zx_spi_pkg::*;
#(
  parameter int CYCLES = SPI_CYCLES_DEFAULT,
  parameter bit FIRST  = 1'b0
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       cen,
  input  logic       reqA,
  input  logic       reqB,
  input  logic       csA,
  input  logic       csB,
  input  logic [7:0] dA,
  input  logic [7:0] dB,
  output logic       ackA,
  output logic       ackB,
  output logic [7:0] q,
  output logic       io,
  output logic [7:0] spiD,
  input  logic [7:0] spiQ,
  output logic       cs
);

  localparam int             CW       = spi_cnt_width(CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(CYCLES - 1);

  spi_state_t    r_state;
  logic          r_owned;
  logic          r_who;
  logic          r_last;
  logic [CW-1:0] r_cnt;
  logic          r_io;
  logic          r_cs;
  logic          r_ack_a;
  logic          r_ack_b;
  logic [7:0]    r_q;
  logic [7:0]    r_spid;

  logic          w_own_req;
  logic          w_own_cs;
  logic [7:0]    w_own_d;
  logic [1:0]    w_contend;
  logic          w_winner;
  logic          w_idle;
  logic          w_grant;
  logic          w_release;
  logic          w_start;
  logic          w_done;

  // Owner's view of the request interface; the other requester is ignored.
  assign w_own_req = r_who ? reqB : reqA;
  assign w_own_cs  = r_who ? csB  : csA;
  assign w_own_d   = r_who ? dB   : dA;

  // A requester contends as soon as it asks for a byte or pulls its cs low.
  assign w_contend = {reqB | ~csB, reqA | ~csA};

  assign w_idle    = (r_state == ST_IDLE);
  assign w_grant   = w_idle & ~r_owned & (|w_contend);
  assign w_release = w_idle &  r_owned & ~w_own_req & w_own_cs;
  assign w_start   = w_idle &  r_owned &  w_own_req;
  assign w_done    = (r_state == ST_DONE);

  spi_rr u_rr (
    .i_req    (w_contend),
    .i_last   (r_last),
    .o_winner (w_winner)
  );

  // Ownership changes only between transfers: grant when free, release when the owner is finished.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_owned <= 1'b0;
      r_who   <= FIRST;
    end else if (w_grant) begin
      r_owned <= 1'b1;
      r_who   <= w_winner;
    end else if (w_release) begin
      r_owned <= 1'b0;
    end
  end

  // Transfer sequencer: strobe the engine, then count cen ticks until the byte is done.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_io    <= 1'b0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            r_state <= ST_START;
            r_io    <= 1'b1;
          end
        end
        ST_START: begin
          // A tick arriving on the IDLE->START edge is not seen here, so it never counts.
          if (cen) begin
            r_state <= ST_BUSY;
            r_io    <= 1'b0;
            r_cnt   <= '0;
          end
        end
        ST_BUSY: begin
          if (cen) begin
            if (r_cnt == CNT_LAST) begin
              r_state <= ST_DONE;
              r_cnt   <= '0;
            end else begin
              r_cnt <= r_cnt + CW'(1);
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Byte datapath and completion pulse; q and ack update together so q is valid with ack.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_spid  <= 8'hFF;
      r_q     <= 8'hFF;
      r_ack_a <= 1'b0;
      r_ack_b <= 1'b0;
      r_last  <= ~FIRST;
    end else begin
      r_ack_a <= w_done & ~r_who;
      r_ack_b <= w_done &  r_who;
      if (w_start) begin
        r_spid <= w_own_d;
      end
      if (w_done) begin
        r_q    <= spiQ;
        r_last <= r_who;
      end
    end
  end

  // Card chip select follows the owner's cs one clock late and idles high when unowned.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_cs <= 1'b1;
    end else begin
      r_cs <= r_owned ? w_own_cs : 1'b1;
    end
  end

  assign ackA = r_ack_a;
  assign ackB = r_ack_b;
  assign q    = r_q;
  assign io   = r_io;
  assign spiD = r_spid;
  assign cs   = r_cs;

endmodule

// File: tb/tb_spi_arbiter.sv
`timescale 1ns/1ps
// Bench for spi_arbiter: two instances (CYCLES=16 and CYCLES=8), random data,
// random or continuous cen, and a transaction-level reference model.
module tb_spi_arbiter;

  localparam int C1      = 16;
  localparam int C2      = 8;
  localparam bit FIRST_P = 1'b0;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       cen   = 1'b0;
  logic       reqA  = 1'b0, reqB = 1'b0, csA = 1'b1, csB = 1'b1;
  logic [7:0] dA    = 8'h00, dB = 8'h00, spiQ = 8'h00;
  logic       ackA, ackB, io, cs;
  logic [7:0] q, spiD;

  logic       reqA2 = 1'b0, csA2 = 1'b1, reqB2 = 1'b0, csB2 = 1'b1;
  logic [7:0] dB2   = 8'h00;
  logic       ackA2, ackB2, io2, cs2;
  logic [7:0] q2, spiD2;

  int checks   = 0;
  int failures = 0;

  // Monitor state (written only by the monitor process).
  bit         cen_always  = 1'b1;
  int         tick_total  = 0;
  int         strobe_tick = 0;
  int         ack_tick    = 0;
  int         strobe_cnt  = 0;
  int         ackA_total  = 0;
  int         ackB_total  = 0;
  logic [7:0] strobe_d    = 8'h00;
  logic       io_prev     = 1'b0;

  // Reference model: the requester served most recently (-1 = none since reset).
  int model_last = -1;

  always #5 clk = ~clk;

  spi_arbiter #(.CYCLES(C1), .FIRST(FIRST_P)) u_dut (
    .clock(clk), .reset(rst_n), .cen(cen),
    .reqA(reqA), .reqB(reqB), .csA(csA), .csB(csB), .dA(dA), .dB(dB),
    .ackA(ackA), .ackB(ackB), .q(q), .io(io), .spiD(spiD), .spiQ(spiQ), .cs(cs)
  );

  spi_arbiter #(.CYCLES(C2), .FIRST(FIRST_P)) u_dut8 (
    .clock(clk), .reset(rst_n), .cen(cen),
    .reqA(reqA2), .reqB(reqB2), .csA(csA2), .csB(csB2), .dA(dA), .dB(dB2),
    .ackA(ackA2), .ackB(ackB2), .q(q2), .io(io2), .spiD(spiD2), .spiQ(spiQ), .cs(cs2)
  );

  function automatic int model_tie_winner();
    return (model_last < 0) ? int'(FIRST_P) : 1 - model_last;
  endfunction

  // Monitor on the falling edge: count cen ticks applied at the last rising
  // edge, log engine strobes and acks, then drive the next cen value.
  initial begin
    forever begin
      @(negedge clk);
      tick_total += (cen ? 1 : 0);
      if (io && !io_prev) begin
        strobe_cnt++;
        strobe_tick = tick_total;
        strobe_d    = spiD;
      end
      io_prev = io;
      if (ackA) begin ackA_total++; ack_tick = tick_total; end
      if (ackB) begin ackB_total++; ack_tick = tick_total; end
      cen = cen_always ? 1'b1 : ($urandom_range(0, 2) == 0);
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  // Waits (bounded) for an ack on the first instance; which=-1 on timeout.
  task automatic wait_ack(output int which, output int cycles);
    which  = -1;
    cycles = 0;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk); #1;
      cycles++;
      if (ackA) begin which = 0; break; end
      if (ackB) begin which = 1; break; end
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    reqA = 1'b0; reqB = 1'b0; csA = 1'b1; csB = 1'b1;
    repeat (3) begin @(negedge clk); #1; end
    rst_n = 1'b1;
    model_last = -1;
    repeat (2) begin @(negedge clk); #1; end
  endtask

  task automatic test_reset();
    @(negedge clk); #1;
    checks++; if (io !== 1'b0)      begin failures++; $display("FAIL reset_io: got %b expected 0", io); end
    checks++; if (cs !== 1'b1)      begin failures++; $display("FAIL reset_cs: got %b expected 1", cs); end
    checks++; if ({ackA, ackB} !== 2'b00) begin failures++; $display("FAIL reset_ack: got %b expected 00", {ackA, ackB}); end
    checks++; if (q !== 8'hFF)      begin failures++; $display("FAIL reset_q: got %h expected ff", q); end
    checks++; if (spiD !== 8'hFF)   begin failures++; $display("FAIL reset_spiD: got %h expected ff", spiD); end
    checks++; if ({q2, spiD2, cs2, io2} !== {8'hFF, 8'hFF, 1'b1, 1'b0})
      begin failures++; $display("FAIL reset_dut8: got q=%h spiD=%h cs=%b io=%b expected ff ff 1 0", q2, spiD2, cs2, io2); end
    rst_n = 1'b1;
    repeat (4) begin @(negedge clk); #1; end
    checks++; if ({io, cs} !== 2'b01) begin failures++; $display("FAIL reset_idle: got io,cs=%b expected 01", {io, cs}); end
    $display("test_reset done");
  endtask

  task automatic test_single();
    int which, cyc, s0, a0, b0;
    logic [7:0] ed, eq;
    for (int n = 0; n < 4; n++) begin
      cen_always = (n == 0);
      ed = (n == 0) ? 8'h40 : 8'($urandom);
      eq = (n == 0) ? 8'hA5 : 8'($urandom);
      dA = ed; spiQ = eq; csA = 1'b0;
      s0 = strobe_cnt; a0 = ackA_total; b0 = ackB_total;
      reqA = 1'b1;
      wait_ack(which, cyc);
      checks++; if (which != 0)   begin failures++; $display("FAIL single_who[%0d]: got %0d expected 0", n, which); end
      checks++; if (q !== eq)     begin failures++; $display("FAIL single_q[%0d]: got %h expected %h", n, q, eq); end
      checks++; if (strobe_d !== ed) begin failures++; $display("FAIL single_spiD[%0d]: got %h expected %h", n, strobe_d, ed); end
      checks++; if (cs !== 1'b0)  begin failures++; $display("FAIL single_cs[%0d]: got %b expected 0", n, cs); end
      checks++; if (strobe_cnt - s0 != 1) begin failures++; $display("FAIL single_strobes[%0d]: got %0d expected 1", n, strobe_cnt - s0); end
      if (n == 0) begin
        checks++; if (cyc - 1 != 3 + C1) begin failures++; $display("FAIL single_latency: got %0d ticks expected %0d", cyc - 1, 3 + C1); end
      end else begin
        checks++;
        if ((ack_tick - strobe_tick < 1 + C1) || (ack_tick - strobe_tick > 2 + C1)) begin
          failures++; $display("FAIL single_ticks[%0d]: got %0d expected %0d..%0d", n, ack_tick - strobe_tick, 1 + C1, 2 + C1);
        end
      end
      model_last = 0;
      reqA = 1'b0; csA = 1'b1;
      repeat (4) begin @(negedge clk); #1; end
      checks++; if ((ackA_total - a0 != 1) || (ackB_total != b0))
        begin failures++; $display("FAIL single_acks[%0d]: got A=%0d B=%0d expected A=1 B=0", n, ackA_total - a0, ackB_total - b0); end
      checks++; if (cs !== 1'b1) begin failures++; $display("FAIL single_release_cs[%0d]: got %b expected 1", n, cs); end
      $display("test_single[%0d] d=%h q=%h ticks=%0d", n, ed, eq, ack_tick - strobe_tick);
    end
  endtask

  task automatic test_tie();
    int which, cyc, win;
    logic [7:0] eqa, eqb;
    do_reset();
    cen_always = 1'b0;
    for (int r = 0; r < 2; r++) begin
      win = model_tie_winner();
      dA = 8'($urandom); dB = 8'($urandom); eqa = 8'($urandom); spiQ = eqa;
      csA = 1'b0; csB = 1'b0; reqA = 1'b1; reqB = 1'b1;
      wait_ack(which, cyc);
      checks++; if (which != win) begin failures++; $display("FAIL tie_first[%0d]: got %0d expected %0d", r, which, win); end
      checks++; if (strobe_d !== (win == 1 ? dB : dA)) begin failures++; $display("FAIL tie_first_spiD[%0d]: got %h expected %h", r, strobe_d, (win == 1 ? dB : dA)); end
      checks++; if (q !== eqa) begin failures++; $display("FAIL tie_first_q[%0d]: got %h expected %h", r, q, eqa); end
      model_last = win;
      eqb = 8'($urandom); spiQ = eqb;
      if (win == 0) begin reqA = 1'b0; csA = 1'b1; end else begin reqB = 1'b0; csB = 1'b1; end
      wait_ack(which, cyc);
      checks++; if (which != 1 - win) begin failures++; $display("FAIL tie_second[%0d]: got %0d expected %0d", r, which, 1 - win); end
      checks++; if (strobe_d !== (win == 1 ? dA : dB)) begin failures++; $display("FAIL tie_second_spiD[%0d]: got %h expected %h", r, strobe_d, (win == 1 ? dA : dB)); end
      checks++; if (q !== eqb) begin failures++; $display("FAIL tie_second_q[%0d]: got %h expected %h", r, q, eqb); end
      model_last = 1 - win;
      reqA = 1'b0; csA = 1'b1; reqB = 1'b0; csB = 1'b1;
      repeat (3) begin @(negedge clk); #1; end
      $display("test_tie[%0d] first=%0d second=%0d", r, win, 1 - win);
    end
  endtask

  task automatic test_hold_cs();
    int which, cyc, bad;
    logic [7:0] ed, eq;
    cen_always = 1'b0;
    ed = 8'($urandom); eq = 8'($urandom); dA = ed; spiQ = eq;
    csA = 1'b0; reqA = 1'b1; csB = 1'b1; reqB = 1'b0;
    wait_ack(which, cyc);
    checks++; if (which != 0) begin failures++; $display("FAIL hold_first: got %0d expected 0", which); end
    model_last = 0;
    reqA = 1'b0; reqB = 1'b1; dB = 8'($urandom);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); #1;
      if (cs !== 1'b0 || ackB !== 1'b0) bad++;
    end
    checks++; if (bad != 0) begin failures++; $display("FAIL hold_window: got %0d bad cycles expected 0", bad); end
    ed = 8'($urandom); eq = 8'($urandom); dA = ed; spiQ = eq; reqA = 1'b1;
    wait_ack(which, cyc);
    checks++; if (which != 0) begin failures++; $display("FAIL hold_retoggle: got %0d expected 0", which); end
    checks++; if (strobe_d !== ed) begin failures++; $display("FAIL hold_retoggle_spiD: got %h expected %h", strobe_d, ed); end
    model_last = 0;
    reqA = 1'b0;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); #1;
      if (cs !== 1'b0 || ackB !== 1'b0) bad++;
    end
    checks++; if (bad != 0) begin failures++; $display("FAIL hold_window2: got %0d bad cycles expected 0", bad); end
    eq = 8'($urandom); spiQ = eq; csA = 1'b1;
    wait_ack(which, cyc);
    checks++; if (which != 1) begin failures++; $display("FAIL hold_handover: got %0d expected 1", which); end
    checks++; if (strobe_d !== dB) begin failures++; $display("FAIL hold_handover_spiD: got %h expected %h", strobe_d, dB); end
    checks++; if (q !== eq) begin failures++; $display("FAIL hold_handover_q: got %h expected %h", q, eq); end
    model_last = 1;
    reqB = 1'b0; csB = 1'b1;
    repeat (3) begin @(negedge clk); #1; end
    $display("test_hold_cs B granted after A released");
  endtask

  task automatic test_back_to_back();
    int which, cyc, s0, a0, b0;
    logic [7:0] ed, eq;
    cen_always = 1'b0;
    s0 = strobe_cnt; a0 = ackA_total; b0 = ackB_total;
    ed = 8'($urandom); eq = 8'($urandom); dA = ed; spiQ = eq;
    csA = 1'b0; reqA = 1'b1;
    repeat (3) begin @(negedge clk); #1; end
    dB = 8'($urandom); csB = 1'b0; reqB = 1'b1;
    for (int k = 0; k < 3; k++) begin
      wait_ack(which, cyc);
      checks++; if (which != 0) begin failures++; $display("FAIL b2b_who[%0d]: got %0d expected 0", k, which); end
      checks++; if (strobe_d !== ed) begin failures++; $display("FAIL b2b_spiD[%0d]: got %h expected %h", k, strobe_d, ed); end
      checks++; if (q !== eq) begin failures++; $display("FAIL b2b_q[%0d]: got %h expected %h", k, q, eq); end
      model_last = 0;
      $display("test_back_to_back[%0d] d=%h q=%h", k, ed, eq);
      ed = 8'($urandom); eq = 8'($urandom); dA = ed; spiQ = eq;
    end
    reqA = 1'b0; csA = 1'b1;
    checks++; if (ackB_total != b0) begin failures++; $display("FAIL b2b_no_b: got %0d B acks expected 0", ackB_total - b0); end
    wait_ack(which, cyc);
    checks++; if (which != 1) begin failures++; $display("FAIL b2b_then_b: got %0d expected 1", which); end
    checks++; if (strobe_d !== dB) begin failures++; $display("FAIL b2b_b_spiD: got %h expected %h", strobe_d, dB); end
    model_last = 1;
    reqB = 1'b0; csB = 1'b1;
    repeat (3) begin @(negedge clk); #1; end
    checks++; if (strobe_cnt - s0 != 4 || ackA_total - a0 != 3)
      begin failures++; $display("FAIL b2b_counts: got strobes=%0d A=%0d expected 4 3", strobe_cnt - s0, ackA_total - a0); end
  endtask

  task automatic test_reset_mid();
    int which, cyc, s0, a0, b0;
    bit found;
    logic [7:0] ed, eq;
    for (int ph = 0; ph < 2; ph++) begin
      cen_always = 1'b1;
      a0 = ackA_total; b0 = ackB_total; s0 = strobe_cnt;
      dA = 8'($urandom); spiQ = 8'($urandom); csA = 1'b0; reqA = 1'b1;
      found = 1'b0;
      for (int i = 0; i < 50 && !found; i++) begin
        @(negedge clk); #1;
        if (strobe_cnt != s0) found = 1'b1;
      end
      checks++; if (!found) begin failures++; $display("FAIL rmid_strobe[%0d]: got none expected 1", ph); end
      if (ph == 1) repeat (8) begin @(negedge clk); #1; end
      checks++; if (io !== (ph == 0) || cs !== 1'b0)
        begin failures++; $display("FAIL rmid_pre[%0d]: got io=%b cs=%b expected io=%0d cs=0", ph, io, cs, (ph == 0)); end
      #2;
      rst_n = 1'b0; reqA = 1'b0; csA = 1'b1;
      #1;
      checks++; if (io !== 1'b0 || cs !== 1'b1)
        begin failures++; $display("FAIL rmid_async[%0d]: got io=%b cs=%b expected io=0 cs=1", ph, io, cs); end
      repeat (2) begin @(negedge clk); #1; end
      rst_n = 1'b1;
      model_last = -1;
      repeat (30) begin @(negedge clk); #1; end
      checks++; if (ackA_total != a0 || ackB_total != b0)
        begin failures++; $display("FAIL rmid_noack[%0d]: got A=%0d B=%0d expected 0 0", ph, ackA_total - a0, ackB_total - b0); end
      $display("test_reset_mid[%0d] reset applied", ph);
    end
    ed = 8'($urandom); eq = 8'($urandom); dA = ed; spiQ = eq; csA = 1'b0; reqA = 1'b1;
    wait_ack(which, cyc);
    checks++; if (which != 0) begin failures++; $display("FAIL rmid_after_who: got %0d expected 0", which); end
    checks++; if (cyc - 1 != 3 + C1) begin failures++; $display("FAIL rmid_after_latency: got %0d expected %0d", cyc - 1, 3 + C1); end
    checks++; if (q !== eq || strobe_d !== ed)
      begin failures++; $display("FAIL rmid_after_data: got q=%h d=%h expected %h %h", q, strobe_d, eq, ed); end
    model_last = 0;
    reqA = 1'b0; csA = 1'b1;
    repeat (4) begin @(negedge clk); #1; end
  endtask

  task automatic test_cycles8();
    int cyc, io_hi, bad;
    bit got;
    logic [7:0] ed, eq;
    cen_always = 1'b1;
    ed = 8'($urandom); eq = 8'($urandom); dA = ed; spiQ = eq;
    csA2 = 1'b0; reqA2 = 1'b1;
    cyc = 0; io_hi = 0; bad = 0; got = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk); #1;
      cyc++;
      if (io2) io_hi++;
      if (ackB2) bad++;
      if (ackA2) got = 1'b1;
    end
    checks++; if (!got) begin failures++; $display("FAIL c8_ack: got none expected ackA"); end
    checks++; if (cyc - 1 != 3 + C2) begin failures++; $display("FAIL c8_latency: got %0d ticks expected %0d", cyc - 1, 3 + C2); end
    checks++; if (q2 !== eq || spiD2 !== ed) begin failures++; $display("FAIL c8_data: got q=%h d=%h expected %h %h", q2, spiD2, eq, ed); end
    checks++; if (io_hi != 1 || bad != 0) begin failures++; $display("FAIL c8_io: got io_cycles=%0d ackB=%0d expected 1 0", io_hi, bad); end
    checks++; if (cs2 !== 1'b0) begin failures++; $display("FAIL c8_cs: got %b expected 0", cs2); end
    reqA2 = 1'b0; csA2 = 1'b1;
    repeat (4) begin @(negedge clk); #1; end
    $display("test_cycles8 ticks=%0d", cyc - 1);
  endtask

  initial begin
    test_reset();
    test_single();
    test_tie();
    test_hold_cs();
    test_back_to_back();
    test_reset_mid();
    test_cycles8();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
